// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS front end: fetch-state
//                encoding, the IF/ID payload layout, PC constants and the
//                sequential next-PC helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        FS_BOOT    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_HOLD    = 2'd2,
        FS_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IF/ID payload: 1 + 32 + 32 = 65 bits
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    // Sequential successor of a PC; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register (65 bits: valid, instr, pc4).
//                Synchronous reset to {0, NOP, 0}; flush clears the valid bit
//                and has priority over load; otherwise the register holds.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - capture i_d
//                i_flush         - invalidate the held entry
//                i_d / o_q       - payload in / out
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0};
        end else if (i_flush) begin
            // Only the valid bit matters to decode; payload bits are left as-is.
            r_q.valid <= 1'b0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : MIPS instruction-fetch stage. Issues instruction-memory
//                requests for the current PC, computes the next PC for the
//                external PC register, and owns the IF/ID register including
//                stall hold (via a one-entry buffer) and redirect flush
//                (via a DISCARD state that drains a stale request).
//  Ports       : clk, rst                 - clock, sync active-high reset
//                pc_q / pc_d              - PC register Q in, D out (comb.)
//                imem_req/addr/ready/rdata- instruction memory handshake
//                stall                    - hold IF/ID
//                redirect / redirect_pc   - taken branch / jump target
//                if_id_valid/instr/pc4    - registered IF/ID outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    // Word captured while stalled, plus its pc4
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc4;
    // Address of a request still in flight after a redirect
    logic [31:0] r_stale_addr;

    logic [31:0] w_pc_plus4;
    logic        w_ifid_load;
    logic        w_ifid_flush;
    logic        w_buf_capture;
    logic        w_buf_drop;
    logic        w_stale_latch;
    if_id_t      w_ifid_d;
    if_id_t      w_ifid_q;

    assign w_pc_plus4 = next_seq_pc(pc_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and IF/ID / buffer control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ifid_load   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_buf_capture = 1'b0;
        w_buf_drop    = 1'b0;
        w_stale_latch = 1'b0;
        w_ifid_d      = '{valid: 1'b1, instr: imem_rdata, pc4: w_pc_plus4};

        case (r_state)
            FS_BOOT: begin
                // One idle cycle so the PC register can capture RESET_PC.
                w_state_nxt = FS_FETCH;
            end

            FS_FETCH: begin
                if (redirect) begin
                    w_ifid_flush = 1'b1;
                    w_buf_drop   = 1'b1;
                    if (!imem_ready) begin
                        // The outstanding request must still be drained.
                        w_stale_latch = 1'b1;
                        w_state_nxt   = FS_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        w_ifid_load = 1'b1;
                    end else begin
                        w_buf_capture = 1'b1;
                        w_state_nxt   = FS_HOLD;
                    end
                end else if (!stall) begin
                    // No word this cycle: decode sees a bubble.
                    w_ifid_flush = 1'b1;
                end
            end

            FS_HOLD: begin
                if (redirect) begin
                    w_ifid_flush = 1'b1;
                    w_buf_drop   = 1'b1;
                    w_state_nxt  = FS_FETCH;
                end else if (!stall) begin
                    w_ifid_load = 1'b1;
                    w_ifid_d    = '{valid: 1'b1, instr: r_buf_instr, pc4: r_buf_pc4};
                    w_buf_drop  = 1'b1;
                    w_state_nxt = FS_FETCH;
                end
            end

            FS_DISCARD: begin
                if (redirect) begin
                    w_ifid_flush = 1'b1;
                    w_buf_drop   = 1'b1;
                end else begin
                    if (!stall) begin
                        w_ifid_flush = 1'b1;
                    end
                    // pc_q already holds the redirect target here.
                    if (imem_ready) begin
                        w_state_nxt = FS_FETCH;
                    end
                end
            end

            default: begin
                w_state_nxt = FS_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall buffer and stale-address register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_instr  <= NOP_INSTR;
            r_buf_pc4    <= 32'h0;
            r_stale_addr <= 32'h0;
        end else begin
            if (w_buf_capture) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc4   <= w_pc_plus4;
            end else if (w_buf_drop) begin
                r_buf_instr <= NOP_INSTR;
                r_buf_pc4   <= 32'h0;
            end
            if (w_stale_latch) begin
                r_stale_addr <= pc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational memory interface and next-PC mux
    // ------------------------------------------------------------------
    // Gating with rst abandons any request the moment reset is asserted.
    assign imem_req  = !rst && ((r_state == FS_FETCH) || (r_state == FS_DISCARD));
    assign imem_addr = (r_state == FS_DISCARD) ? r_stale_addr : pc_q;

    always_comb begin
        pc_d = pc_q;
        if (rst) begin
            pc_d = RESET_PC;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if ((r_state == FS_FETCH) && imem_ready) begin
            pc_d = w_pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign if_id_valid = w_ifid_q.valid;
    assign if_id_instr = w_ifid_q.instr;
    assign if_id_pc4   = w_ifid_q.pc4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Provides the
//                external PC register and an instruction memory with a
//                programmable number of wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    int          total = 0;
    int          bad   = 0;

    logic [3:0]  wait_cfg;
    logic [3:0]  r_wcnt;
    logic        force_ready;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_q        (pc_q),
        .pc_d        (pc_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
    );

    // External PC register
    always_ff @(posedge clk) pc_q <= pc_d;

    // Memory contents: a fixed, address-dependent pattern
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0001;
    endfunction

    // Wait-state counter: ready after wait_cfg idle cycles of a request
    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ready) r_wcnt <= 4'd0;
        else                                r_wcnt <= r_wcnt + 4'd1;
    end

    assign imem_ready = force_ready | (imem_req && (r_wcnt >= wait_cfg));
    assign imem_rdata = word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        wait_cfg = 4'd0; force_ready = 1'b0;

        // ---------------- reset, then zero-wait streaming ----------------
        tick; tick;
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        rst = 1'b0; #1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        chk("boot_pc_d", pc_d, 32'h0);
        tick;
        chk("f0_req", {31'h0, imem_req}, 32'h1);
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_pc_d", pc_d, 32'h4);
        tick;
        chk("s1_valid", {31'h0, if_id_valid}, 32'h1);
        chk("s1_instr", if_id_instr, word(32'h0));
        chk("s1_pc4", if_id_pc4, 32'h4);
        chk("s1_pc_d", pc_d, 32'h8);
        tick;
        chk("s2_instr", if_id_instr, word(32'h4));
        chk("s2_pc4", if_id_pc4, 32'h8);
        tick;
        chk("s3_instr", if_id_instr, word(32'h8));
        chk("s3_pc4", if_id_pc4, 32'hC);

        // ---------------- two wait states at 0xC ----------------
        wait_cfg = 4'd2; #1;
        chk("w0_addr", imem_addr, 32'hC);
        chk("w0_pc_d", pc_d, 32'hC);
        tick;
        chk("w1_valid", {31'h0, if_id_valid}, 32'h0);
        chk("w1_addr", imem_addr, 32'hC);
        chk("w1_req", {31'h0, imem_req}, 32'h1);
        tick;
        chk("w2_addr", imem_addr, 32'hC);
        chk("w2_pc_d", pc_d, 32'h10);
        tick;
        chk("w3_valid", {31'h0, if_id_valid}, 32'h1);
        chk("w3_instr", if_id_instr, word(32'hC));
        chk("w3_pc4", if_id_pc4, 32'h10);

        // ---------------- stall coinciding with ready at 0x10 ----------------
        wait_cfg = 4'd0; stall = 1'b1; #1;
        chk("st_addr", imem_addr, 32'h10);
        chk("st_pc_d", pc_d, 32'h14);
        tick;
        chk("h1_req", {31'h0, imem_req}, 32'h0);
        chk("h1_instr", if_id_instr, word(32'hC));
        chk("h1_pc4", if_id_pc4, 32'h10);
        chk("h1_pc_d", pc_d, 32'h14);
        tick;
        chk("h2_instr", if_id_instr, word(32'hC));
        chk("h2_pc4", if_id_pc4, 32'h10);
        tick;
        stall = 1'b0; #1;
        chk("h3_pc4", if_id_pc4, 32'h10);
        chk("h3_req", {31'h0, imem_req}, 32'h0);
        tick;
        chk("hx_valid", {31'h0, if_id_valid}, 32'h1);
        chk("hx_instr", if_id_instr, word(32'h10));
        chk("hx_pc4", if_id_pc4, 32'h14);
        chk("hx_addr", imem_addr, 32'h14);

        // ---------------- redirect while waiting on 0x20 ----------------
        tick; tick; tick;
        wait_cfg = 4'd2; #1;
        chk("r0_addr", imem_addr, 32'h20);
        chk("r0_pc4", if_id_pc4, 32'h20);
        redirect = 1'b1; redirect_pc = 32'h400; #1;
        chk("r0_pc_d", pc_d, 32'h400);
        tick;
        redirect = 1'b0; #1;
        chk("d1_valid", {31'h0, if_id_valid}, 32'h0);
        chk("d1_addr", imem_addr, 32'h20);
        chk("d1_req", {31'h0, imem_req}, 32'h1);
        chk("d1_pc_d", pc_d, 32'h400);
        tick;
        chk("d2_addr", imem_addr, 32'h20);
        chk("d2_pc_d", pc_d, 32'h400);
        tick;
        chk("d3_addr", imem_addr, 32'h400);
        chk("d3_valid", {31'h0, if_id_valid}, 32'h0);
        wait_cfg = 4'd0;
        tick;
        chk("d4_instr", if_id_instr, word(32'h400));
        chk("d4_pc4", if_id_pc4, 32'h404);

        // ---------------- redirect and stall together in HOLD ----------------
        stall = 1'b1;
        tick;
        redirect = 1'b1; redirect_pc = 32'h800; #1;
        chk("rh_pc_d", pc_d, 32'h800);
        chk("rh_req", {31'h0, imem_req}, 32'h0);
        chk("rh_pc4", if_id_pc4, 32'h404);
        tick;
        stall = 1'b0; redirect = 1'b0; #1;
        chk("rh1_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rh1_req", {31'h0, imem_req}, 32'h1);
        chk("rh1_addr", imem_addr, 32'h800);
        tick;
        chk("rh2_instr", if_id_instr, word(32'h800));
        chk("rh2_pc4", if_id_pc4, 32'h804);

        // ---------------- wrap at the top of the address space ----------------
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        tick;
        redirect = 1'b0; #1;
        chk("wr_valid", {31'h0, if_id_valid}, 32'h0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_pc_d", pc_d, 32'h0);
        tick;
        chk("wr_pc4", if_id_pc4, 32'h0);
        chk("wr_instr", if_id_instr, word(32'hFFFF_FFFC));
        chk("wr_valid2", {31'h0, if_id_valid}, 32'h1);

        // ---------------- reset during DISCARD ----------------
        wait_cfg = 4'd2; redirect = 1'b1; redirect_pc = 32'h100; #1;
        tick;
        redirect = 1'b0; rst = 1'b1; #1;
        chk("rd_pc_d", pc_d, 32'h0);
        chk("rd_req", {31'h0, imem_req}, 32'h0);
        tick;
        chk("rd1_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rd1_instr", if_id_instr, 32'h0);
        chk("rd1_pc4", if_id_pc4, 32'h0);
        chk("rd1_req", {31'h0, imem_req}, 32'h0);
        chk("rd1_pc_d", pc_d, 32'h0);
        rst = 1'b0; force_ready = 1'b1; #1;
        chk("bl_pc_d", pc_d, 32'h0);
        chk("bl_req", {31'h0, imem_req}, 32'h0);
        tick;
        force_ready = 1'b0; wait_cfg = 4'd0; #1;
        chk("bl1_valid", {31'h0, if_id_valid}, 32'h0);
        chk("bl1_addr", imem_addr, 32'h0);
        chk("bl1_req", {31'h0, imem_req}, 32'h1);
        tick;
        chk("bl2_instr", if_id_instr, word(32'h0));
        chk("bl2_pc4", if_id_pc4, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
